// File: rtl/nios_system_onchip_memory_loader.sv
// Byte-stream to 32-bit word loader feeding the on-chip RAM's s2 port.
// Optional running checksum of written words: define NIOS_SYSTEM_ONCHIP_LOADER_CHECKSUM_EN.
module nios_system_onchip_memory_loader #(
    parameter int MEM_DEPTH = 50000,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_r;
    logic [ADDR_W-1:0] remaining_r;
    logic [1:0]        byte_idx_r;
    logic [ADDR_W:0]   end_addr_s;
    logic              range_bad_s;

    // One bit wider than the address so a base near the top cannot wrap past the check.
    assign end_addr_s     = {1'b0, base_addr} + {1'b0, word_count};
    assign range_bad_s    = (end_addr_s > DEPTH_LIMIT);
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    // Load sequencer: start capture, byte packing, one-cycle write strobe, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            remaining_r    <= '0;
            byte_idx_r     <= 2'd0;
            in_ready       <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mem_address <= base_addr;
                        remaining_r <= word_count;
                        byte_idx_r  <= 2'd0;
                        busy        <= 1'b1;
                        error       <= range_bad_s;
                        if ((word_count == '0) || range_bad_s) begin
                            state_r <= FINISH;
                        end else begin
                            state_r  <= COLLECT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        case (byte_idx_r)
                            2'd0:    mem_writedata[7:0]   <= in_data;
                            2'd1:    mem_writedata[15:8]  <= in_data;
                            2'd2:    mem_writedata[23:16] <= in_data;
                            2'd3:    mem_writedata[31:24] <= in_data;
                            default: mem_writedata[7:0]   <= in_data;
                        endcase
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            in_ready       <= 1'b0;
                            mem_write      <= 1'b1;
                            mem_chipselect <= 1'b1;
                            state_r        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    mem_write      <= 1'b0;
                    mem_chipselect <= 1'b0;
                    mem_address    <= mem_address + {{(ADDR_W-1){1'b0}}, 1'b1};
                    remaining_r    <= remaining_r - {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (remaining_r == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        state_r <= FINISH;
                    end else begin
                        state_r  <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    in_ready       <= 1'b0;
                    mem_write      <= 1'b0;
                    mem_chipselect <= 1'b0;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                end
            endcase
        end
    end

`ifdef NIOS_SYSTEM_ONCHIP_LOADER_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Running mod-2^32 sum of every word strobed into RAM since the last accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_r <= 32'h0;
        end else if ((state_r == IDLE) && start) begin
            checksum_r <= 32'h0;
        end else if (state_r == WRITE) begin
            checksum_r <= checksum_r + mem_writedata;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_nios_system_onchip_memory_loader.sv
// Scoreboard bench for nios_system_onchip_memory_loader: expected RAM writes are queued
// before stimulus and popped by a write monitor.
module tb_nios_system_onchip_memory_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int errors = 0;
    int checks = 0;
    int write_count = 0;
    logic [47:0] exp_q[$];
    logic [7:0]  stim_q[$];

    nios_system_onchip_memory_loader #(.MEM_DEPTH(50000), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest queued {address, data}.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            logic [47:0] exp_w;
            write_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_address, mem_writedata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_address, mem_writedata} !== exp_w || mem_chipselect !== 1'b1 || mem_byteenable !== 4'hF) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h cs=%b be=%h, expected addr=%h data=%h cs=1 be=f",
                             mem_address, mem_writedata, mem_chipselect, mem_byteenable, exp_w[47:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        base_addr = 16'h0; word_count = 16'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] n);
        @(negedge clk);
        base_addr = b; word_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Push one expected word per 4 queued bytes starting at address b.
    task automatic expect_words(input logic [15:0] b);
        for (int w = 0; w < stim_q.size() / 4; w++)
            exp_q.push_back({b + 16'(w), stim_q[4*w+3], stim_q[4*w+2], stim_q[4*w+1], stim_q[4*w]});
    endtask

    // Feed stim_q; optional gaps on odd cycles and an optional start pulse at cycle start_at.
    task automatic feed(input bit gaps, input int start_at);
        int i = 0;
        int cyc = 0;
        while (i < stim_q.size() && cyc < 500) begin
            @(negedge clk);
            if (gaps && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = stim_q[i];
            end
            start = (cyc == start_at);
            if (in_valid && in_ready === 1'b1) i++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        checks++;
        if (i != stim_q.size()) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d bytes, expected %0d", i, stim_q.size());
        end
    endtask

    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic check_end(input string name, input logic exp_err, input int exp_writes, input int w0);
        checks++;
        if (error !== exp_err || exp_q.size() != 0 || (write_count - w0) != exp_writes) begin
            errors++;
            $display("FAIL %s_end: error=%b pending=%0d writes=%0d, expected error=%b pending=0 writes=%0d",
                     name, error, exp_q.size(), write_count - w0, exp_err, exp_writes);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, mem_write, mem_chipselect, busy, done, error} !== 6'b0 ||
            mem_address !== 16'h0 || mem_writedata !== 32'h0 || checksum !== 32'h0 ||
            mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: rdy=%b wr=%b cs=%b busy=%b done=%b err=%b addr=%h data=%h ck=%h be=%h clken=%b, expected zeros be=f clken=1",
                     in_ready, mem_write, mem_chipselect, busy, done, error, mem_address, mem_writedata,
                     checksum, mem_byteenable, mem_clken);
        end
    endtask

    task automatic test_basic();
        int lat;
        int w0 = write_count;
        logic [31:0] exp_ck;
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_words(16'h0010);
        pulse_start(16'h0010, 16'd2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b in_ready=%b, expected 1 1", busy, in_ready);
        end
        feed(1'b0, -1);
        wait_done(20, lat);
        check_end("basic", 1'b0, 2, w0);
`ifdef NIOS_SYSTEM_ONCHIP_LOADER_CHECKSUM_EN
        exp_ck = 32'h0C0A0806;
`else
        exp_ck = 32'h0;
`endif
        checks++;
        if (checksum !== exp_ck) begin
            errors++;
            $display("FAIL basic_checksum: got %h, expected %h", checksum, exp_ck);
        end
    endtask

    task automatic test_range();
        int lat;
        int w0 = write_count;
        pulse_start(16'hC34C, 16'd5);
        wait_done(10, lat);
        check_end("range_reject", 1'b1, 0, w0);
        w0 = write_count;
        stim_q.delete();
        for (int k = 0; k < 20; k++) stim_q.push_back(8'(8'h30 + k));
        expect_words(16'd49995);
        pulse_start(16'd49995, 16'd5);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL range_err_clear: error=%b, expected 0", error);
        end
        feed(1'b0, -1);
        wait_done(20, lat);
        check_end("range_edge", 1'b0, 5, w0);
    endtask

    task automatic test_zero_count();
        int lat;
        int w0 = write_count;
        pulse_start(16'h0005, 16'd0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready: in_ready=%b, expected 0", in_ready);
        end
        wait_done(10, lat);
        // Start sampled at the first edge, done visible after the second.
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL zero_latency: done after %0d extra cycles, expected 1", lat);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: done=%b one cycle later, expected 0", done);
        end
        check_end("zero", 1'b0, 0, w0);
    endtask

    task automatic test_gaps_midstart();
        int lat;
        int w0 = write_count;
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_words(16'h0010);
        pulse_start(16'h0010, 16'd2);
        base_addr = 16'h0100; word_count = 16'd1;
        feed(1'b1, 5);
        wait_done(20, lat);
        check_end("gaps", 1'b0, 2, w0);
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_idle: busy=%b after load, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int w0 = write_count;
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back({16'h0020, 32'h44332211});
        pulse_start(16'h0020, 16'd2);
        feed(1'b0, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b in_ready=%b mem_write=%b, expected 0 0 0", busy, in_ready, mem_write);
        end
        repeat (10) @(negedge clk);
        check_end("midreset", 1'b0, 1, w0);
        w0 = write_count;
        stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        expect_words(16'h0030);
        pulse_start(16'h0030, 16'd1);
        feed(1'b0, -1);
        wait_done(20, lat);
        check_end("after_reset", 1'b0, 1, w0);
    endtask

    task automatic test_checksum();
        int lat;
        int w0 = write_count;
        logic [31:0] exp_ck;
        stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        expect_words(16'h0040);
        pulse_start(16'h0040, 16'd2);
        feed(1'b0, -1);
        wait_done(20, lat);
        check_end("checksum", 1'b0, 2, w0);
`ifdef NIOS_SYSTEM_ONCHIP_LOADER_CHECKSUM_EN
        exp_ck = 32'h00000001;
`else
        exp_ck = 32'h0;
`endif
        checks++;
        if (checksum !== exp_ck) begin
            errors++;
            $display("FAIL checksum_value: got %h, expected %h", checksum, exp_ck);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        base_addr = 16'h0; word_count = 16'h0;
        test_reset();
        test_basic();
        test_range();
        test_zero_count();
        test_gaps_midstart();
        test_reset_mid();
        test_checksum();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
